// File: rtl/alu_arbiter.sv
// Shares one ALU among NReq requesters and returns its result through a one-entry, owner-tagged response slot.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module alu_arbiter #(
    parameter int unsigned NReq = 2,
    parameter int unsigned Xlen = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [NReq-1:0]      req_valid_i,
    output logic [NReq-1:0]      req_ready_o,
    input  logic [2*NReq-1:0]    req_aluop_i,
    input  logic [3*NReq-1:0]    req_funct3_i,
    input  logic [7*NReq-1:0]    req_funct7_i,
    input  logic [NReq-1:0]      req_itype_i,
    input  logic [Xlen*NReq-1:0] req_a_i,
    input  logic [Xlen*NReq-1:0] req_b_i,
    output logic [NReq-1:0]      rsp_valid_o,
    input  logic [NReq-1:0]      rsp_ready_i,
    output logic [Xlen-1:0]      rsp_res_o,
    output logic                 rsp_zero_o
);

    localparam int unsigned IdW = (NReq > 1) ? $clog2(NReq) : 1;
    localparam int unsigned ShW = $clog2(Xlen);

    localparam logic [1:0] OpAdd    = 2'd0;
    localparam logic [1:0] OpSleft  = 2'd1;
    localparam logic [1:0] OpBranch = 2'd2;
    localparam logic [1:0] OpFunct  = 2'd3;

    typedef enum logic {
        SlotEmpty,
        SlotFull
    } slot_e;

    slot_e            state_q, state_d;
    logic [IdW-1:0]   owner_q;
    logic [IdW-1:0]   last_grant_q;
    logic [IdW-1:0]   win;
    logic             any_valid;
    logic             slot_free;
    logic             accept;

    logic [1:0]       op;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             itype;
    logic [Xlen-1:0]  op_a;
    logic [Xlen-1:0]  op_b;
    logic [ShW-1:0]   sh;
    logic             alt;
    logic [Xlen-1:0]  alu_res;
    logic             alu_zero;

    // Winner selection
`ifdef ALU_ARB_RR_EN
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        any_valid = |req_valid_i;
        for (int k = 1; k <= int'(NReq); k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= int'(NReq)) begin
                idx = idx - int'(NReq);
            end
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = IdW'(idx);
            end
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant_q;

    always_comb begin
        win       = '0;
        any_valid = |req_valid_i;
        for (int k = int'(NReq) - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                win = IdW'(k);
            end
        end
    end
`endif

    // Winner's operands steered to the shared ALU
    always_comb begin
        op    = req_aluop_i[win*2 +: 2];
        f3    = req_funct3_i[win*3 +: 3];
        f7    = req_funct7_i[win*7 +: 7];
        itype = req_itype_i[win];
        op_a  = req_a_i[win*Xlen +: Xlen];
        op_b  = req_b_i[win*Xlen +: Xlen];
    end

    // Shared ALU; results not meaningful for the op class are forced to zero
    always_comb begin
        alu_res  = '0;
        alu_zero = 1'b0;
        sh       = op_b[ShW-1:0];
        alt      = (f7 == 7'b0100000);
        case (op)
            OpAdd:   alu_res = op_a + op_b;
            OpSleft: alu_res = op_a << sh;
            OpBranch: begin
                case (f3)
                    3'b000:  alu_zero = (op_a == op_b);
                    3'b001:  alu_zero = (op_a != op_b);
                    3'b100:  alu_zero = ($signed(op_a) <  $signed(op_b));
                    3'b101:  alu_zero = ($signed(op_a) >= $signed(op_b));
                    3'b110:  alu_zero = (op_a <  op_b);
                    3'b111:  alu_zero = (op_a >= op_b);
                    default: alu_zero = 1'b0;
                endcase
            end
            OpFunct: begin
                case (f3)
                    3'b000:  alu_res = (alt && !itype) ? (op_a - op_b) : (op_a + op_b);
                    3'b001:  alu_res = op_a << sh;
                    3'b010:  alu_res = Xlen'($signed(op_a) < $signed(op_b));
                    3'b011:  alu_res = Xlen'(op_a < op_b);
                    3'b100:  alu_res = op_a ^ op_b;
                    3'b101:  alu_res = alt ? Xlen'($signed(op_a) >>> sh) : (op_a >> sh);
                    3'b110:  alu_res = op_a | op_b;
                    default: alu_res = op_a & op_b;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Grant, accept and slot next-state
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        slot_free   = (state_q == SlotEmpty) || rsp_ready_i[owner_q];
        if (any_valid && slot_free && !flush_i && rst_ni) begin
            req_ready_o[win] = 1'b1;
        end
        accept = |(req_valid_i & req_ready_o);
        case (state_q)
            SlotEmpty: begin
                if (accept) begin
                    state_d = SlotFull;
                end
            end
            SlotFull: begin
                if (flush_i) begin
                    state_d = SlotEmpty;
                end else if (rsp_ready_i[owner_q] && !accept) begin
                    state_d = SlotEmpty;
                end
            end
            default: state_d = SlotEmpty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SlotEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Response payload only moves on accept, so a held response stays stable
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_q      <= '0;
            last_grant_q <= IdW'(NReq - 1);
            rsp_res_o    <= '0;
            rsp_zero_o   <= 1'b0;
        end else if (accept) begin
            owner_q      <= win;
            last_grant_q <= win;
            rsp_res_o    <= alu_res;
            rsp_zero_o   <= alu_zero;
        end
    end

    assign rsp_valid_o = (state_q == SlotFull) ? (NReq'(1) << owner_q) : '0;

endmodule
